cross_bar_wrr_arbiter: RTL and testbench

CROSS_BAR_WRR_ARBITER -- requirements
Module: cross_bar_wrr_arbiter

---
 rtl/cross_bar_wrr_arbiter.sv | 139 +++++++++++++
 tb/tb_cross_bar_wrr_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cross_bar_wrr_arbiter.sv
// Weighted round-robin bus arbiter with a registered one-hot grant and a one-cycle turnaround after each release.
// Optional build macro CROSS_BAR_WRR_PRIO_EN adds a prio input that narrows IDLE-time selection to prioritised requesters.
module cross_bar_wrr_arbiter #(
    parameter int MASTER_N = 4,
    parameter int WEIGHT_W = 4
) (
    input  logic                          clk,
    input  logic                          areset,
    input  logic [MASTER_N-1:0]           req,
    input  logic [MASTER_N-1:0]           last,
    input  logic [MASTER_N*WEIGHT_W-1:0]  weight,
`ifdef CROSS_BAR_WRR_PRIO_EN
    input  logic [MASTER_N-1:0]           prio,
`endif
    output logic [MASTER_N-1:0]           grant,
    output logic [$clog2(MASTER_N)-1:0]   grant_idx,
    output logic                          busy
);

    localparam int IDX_W = $clog2(MASTER_N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [IDX_W-1:0]    w_sel;
    logic [IDX_W-1:0]    w_idx_inc;
    logic [WEIGHT_W-1:0] r_credit;
    logic [WEIGHT_W-1:0] w_credit_nxt;
    logic [WEIGHT_W-1:0] w_weight_sel;
    logic [MASTER_N-1:0] r_grant;
    logic [MASTER_N-1:0] w_grant_nxt;
    logic [MASTER_N-1:0] w_cand;
    logic                r_armed;
    logic                w_found;

    function automatic logic [IDX_W-1:0] wrapAdd(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= MASTER_N) begin
            s = s - MASTER_N;
        end
        return IDX_W'(s);
    endfunction

    // Prioritised requesters win selection only when at least one of them is asking.
`ifdef CROSS_BAR_WRR_PRIO_EN
    assign w_cand = (|(req & prio)) ? (req & prio) : req;
`else
    assign w_cand = req;
`endif

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < MASTER_N; k++) begin
            if (!w_found && w_cand[wrapAdd(r_ptr, k)]) begin
                w_found = 1'b1;
                w_sel   = wrapAdd(r_ptr, k);
            end
        end
    end

    assign w_weight_sel = weight[int'(w_sel)*WEIGHT_W +: WEIGHT_W];
    assign w_idx_inc    = wrapAdd(r_idx, 1);

    // Every release (last with final credit, or dropped req) passes through IDLE for one cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_idx_nxt    = r_idx;
        w_credit_nxt = r_credit;
        w_grant_nxt  = r_grant;
        case (r_state)
            IDLE: begin
                if (r_armed && w_found) begin
                    w_state_nxt         = GRANT;
                    w_grant_nxt         = '0;
                    w_grant_nxt[w_sel]  = 1'b1;
                    w_idx_nxt           = w_sel;
                    w_ptr_nxt           = w_sel;
                    w_credit_nxt        = (w_weight_sel == '0) ? WEIGHT_W'(1) : w_weight_sel;
                end
            end
            GRANT: begin
                if (!req[r_idx]) begin
                    w_state_nxt  = IDLE;
                    w_grant_nxt  = '0;
                    w_ptr_nxt    = w_idx_inc;
                    w_credit_nxt = '0;
                end else if (last[r_idx]) begin
                    if (r_credit > WEIGHT_W'(1)) begin
                        w_credit_nxt = r_credit - WEIGHT_W'(1);
                    end else begin
                        w_state_nxt  = IDLE;
                        w_grant_nxt  = '0;
                        w_ptr_nxt    = w_idx_inc;
                        w_credit_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // r_armed holds off granting on the first edge after reset so that edge only samples req.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_credit <= '0;
            r_grant  <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_idx    <= w_idx_nxt;
            r_credit <= w_credit_nxt;
            r_grant  <= w_grant_nxt;
            r_armed  <= 1'b1;
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_idx;
    assign busy      = (r_state == GRANT);

endmodule

// File: tb/tb_cross_bar_wrr_arbiter.sv
// Self-checking bench for cross_bar_wrr_arbiter (MASTER_N=4, WEIGHT_W=4) using vector tables and an expected-grant queue.
// Define CROSS_BAR_WRR_PRIO_EN for the build to also exercise the prio input.
module tb_cross_bar_wrr_arbiter;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  last;
        logic [15:0] weight;
        logic [3:0]  expGrant;
        string       name;
    } vec_t;

    typedef vec_t vecq_t[$];

    localparam logic [15:0] W1 = 16'h1321;
    localparam logic [15:0] W2 = 16'h1121;
    localparam logic [15:0] W3 = 16'h1301;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [15:0] weight;
    logic [3:0]  grant;
    logic [1:0]  grant_idx;
    logic        busy;
`ifdef CROSS_BAR_WRR_PRIO_EN
    logic [3:0]  prio = 4'b0000;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] expQ[$];
    string      nameQ[$];
    vecq_t      tableA;
    vecq_t      tableB;

    cross_bar_wrr_arbiter #(.MASTER_N(4), .WEIGHT_W(4)) dut (
        .clk       (clk),
        .areset    (areset),
        .req       (req),
        .last      (last),
        .weight    (weight),
`ifdef CROSS_BAR_WRR_PRIO_EN
        .prio      (prio),
`endif
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Hard stop so a stuck run still reports.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic compareVal(input string nm, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %b want %b", nm, got, want);
        end
    endtask

    task automatic checkOutput();
        logic [3:0] expG;
        string      nm;
        logic [1:0] expIdx;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty got 0 entries want 1");
            return;
        end
        expG = expQ.pop_front();
        nm   = nameQ.pop_front();
        compareVal({nm, ".grant"}, grant, expG);
        compareVal({nm, ".busy"}, {3'b000, busy}, {3'b000, |expG});
        if (expG != 4'b0000) begin
            expIdx = 2'd0;
            for (int i = 0; i < 4; i++) begin
                if (expG[i]) expIdx = 2'(i);
            end
            compareVal({nm, ".grant_idx"}, {2'b00, grant_idx}, {2'b00, expIdx});
        end
    endtask

    task automatic applyStimulus(input logic [3:0] rq, input logic [3:0] ls, input logic [15:0] wt,
                                 input logic [3:0] expG, input string nm);
        req    = rq;
        last   = ls;
        weight = wt;
        expQ.push_back(expG);
        nameQ.push_back(nm);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic runTable(input vecq_t t);
        foreach (t[i]) begin
            applyStimulus(t[i].req, t[i].last, t[i].weight, t[i].expGrant, t[i].name);
        end
    endtask

    task automatic checkResetOutputs(input string nm);
        compareVal({nm, ".grant"}, grant, 4'b0000);
        compareVal({nm, ".busy"}, {3'b000, busy}, 4'b0000);
        compareVal({nm, ".grant_idx"}, {2'b00, grant_idx}, 4'b0000);
    endtask

    initial begin
        int start;
        int cnt;
        int m;
        logic [3:0] oh;

        // Single master handshake, then m1 with weight 2 to show ptr advanced to 1.
        tableA.push_back('{4'b0001, 4'b0000, W1, 4'b0001, "single_grant"});
        tableA.push_back('{4'b0001, 4'b0001, W1, 4'b0000, "single_release"});
        tableA.push_back('{4'b0000, 4'b0000, W1, 4'b0000, "single_idle"});
        tableA.push_back('{4'b0011, 4'b0000, W1, 4'b0010, "ptr1_pick_m1"});
        tableA.push_back('{4'b0011, 4'b0010, W1, 4'b0010, "m1_credit2"});
        tableA.push_back('{4'b0011, 4'b0010, W1, 4'b0000, "m1_release"});
        tableA.push_back('{4'b0000, 4'b0000, W1, 4'b0000, "idle_a"});

        // Weight change mid-grant, abort coinciding with other requests, zero weight.
        tableB.push_back('{4'b0100, 4'b0000, W1, 4'b0100, "m2_grant"});
        tableB.push_back('{4'b0100, 4'b0100, W2, 4'b0100, "m2_credit_wchg1"});
        tableB.push_back('{4'b0100, 4'b0100, W2, 4'b0100, "m2_credit_wchg2"});
        tableB.push_back('{4'b1011, 4'b1011, W1, 4'b0000, "m2_abort"});
        tableB.push_back('{4'b1111, 4'b0000, W1, 4'b1000, "ptr3_pick_m3"});
        tableB.push_back('{4'b1111, 4'b1000, W1, 4'b0000, "m3_release"});
        tableB.push_back('{4'b0000, 4'b0000, W1, 4'b0000, "idle_b"});
        for (int i = 0; i < 3; i++) begin
            tableB.push_back('{4'b0010, 4'b0010, W3, 4'b0010, "w0_grant"});
            tableB.push_back('{4'b0010, 4'b0010, W3, 4'b0000, "w0_release"});
        end
        tableB.push_back('{4'b0000, 4'b0000, W3, 4'b0000, "idle_c"});

        areset = 1'b1;
        req    = 4'b0000;
        last   = 4'b0000;
        weight = W1;
        #12;
        checkResetOutputs("reset_state");
        #1;
        areset = 1'b0;
        applyStimulus(4'b0001, 4'b0000, W1, 4'b0000, "first_edge_sample_only");
        runTable(tableA);

        // Full-load rotation starting from ptr=2, two complete rounds.
        start = 2;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                m   = (start + k) % 4;
                cnt = int'(W1[m*4 +: 4]);
                if (cnt == 0) cnt = 1;
                oh  = 4'b0001 << m;
                for (int c = 0; c < cnt; c++) begin
                    applyStimulus(4'b1111, 4'b1111, W1, oh, $sformatf("rot%0d_m%0d_x%0d", r, m, c));
                end
                applyStimulus(4'b1111, 4'b1111, W1, 4'b0000, $sformatf("rot%0d_gap_m%0d", r, m));
            end
        end
        applyStimulus(4'b0000, 4'b0000, W1, 4'b0000, "rot_idle");

        runTable(tableB);

        // Asynchronous reset in the middle of an m2 grant.
        applyStimulus(4'b0100, 4'b0000, W1, 4'b0100, "pre_reset_m2");
        #3;
        areset = 1'b1;
        #2;
        checkResetOutputs("async_reset_drop");
        @(posedge clk);
        #3;
        areset = 1'b0;
        applyStimulus(4'b1100, 4'b0000, W1, 4'b0000, "post_reset_sample");
        applyStimulus(4'b1100, 4'b0000, W1, 4'b0100, "post_reset_m2");
        applyStimulus(4'b1000, 4'b0000, W1, 4'b0000, "post_reset_abort");

`ifdef CROSS_BAR_WRR_PRIO_EN
        #3;
        areset = 1'b1;
        #4;
        areset = 1'b0;
        applyStimulus(4'b0000, 4'b0000, W1, 4'b0000, "prio_sample");
        prio = 4'b1000;
        applyStimulus(4'b1011, 4'b0000, W1, 4'b1000, "prio_m3");
        prio = 4'b0001;
        applyStimulus(4'b1011, 4'b0000, W1, 4'b1000, "prio_no_preempt");
        prio = 4'b0000;
        applyStimulus(4'b0000, 4'b0000, W1, 4'b0000, "prio_abort");
        applyStimulus(4'b1011, 4'b0000, W1, 4'b0001, "noprio_m0");
        applyStimulus(4'b0000, 4'b0000, W1, 4'b0000, "noprio_abort");
`endif

        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_leftover got %0d want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
